// File: rtl/interrupt_claim_arbiter.sv
// interrupt_claim_arbiter
//   Per-source interrupt gateways plus the claim/complete arbiter. Each source
//   has a three-state gateway (idle, pending, in service). The highest-priority
//   pending, unmasked source is registered as best_id, and the core interrupt
//   line follows it. A bus read of the claim/complete register claims best_id.
//   A bus write of an ID to that register completes the matching source.
//
// Ports
//   clk                      system clock, rising edge
//   n_rst                    asynchronous active-low reset
//   interrupt_requests       level-sensitive source lines
//   interrupt_masks          1 = source masked
//   interrupt_priority_regs  per-source 32-bit priority, larger is more urgent
//   claim_complete_addr      bus address of the claim/complete register
//   addr, ren, wen, wdata    single-cycle bus access
//   rdata                    best_id when addr_valid, else 0
//   addr_valid               addr == claim_complete_addr
//   interrupt_pending        registered per-source pending bits
//   interrupt_req            registered; high while a claimable source exists

module interrupt_claim_arbiter #(
    parameter int unsigned N_interrupts = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [N_interrupts-1:0]       interrupt_requests,
    input  logic [N_interrupts-1:0]       interrupt_masks,
    input  logic [N_interrupts-1:0][31:0] interrupt_priority_regs,
    input  logic [31:0]                   claim_complete_addr,
    input  logic [31:0]                   addr,
    input  logic                          ren,
    input  logic                          wen,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata,
    output logic                          addr_valid,
    output logic [N_interrupts-1:0]       interrupt_pending,
    output logic                          interrupt_req
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPending   = 2'd1,
        StInService = 2'd2
    } gw_state_e;

    gw_state_e                 state_q [N_interrupts];
    gw_state_e                 state_d [N_interrupts];
    logic [N_interrupts-1:0]   pending_q, pending_d;
    logic [31:0]               best_id_q, best_id_d;
    logic                      req_q, req_d;
    logic [31:0]               best_prio;
    logic                      claim;
    logic                      complete;

    assign addr_valid = (addr == claim_complete_addr);
    // A simultaneous write wins; the read is then not a claim.
    assign claim      = ren & addr_valid & ~wen;
    assign complete   = wen & addr_valid;
    assign rdata      = addr_valid ? best_id_q : 32'd0;

    // Gateway next state. The claim uses the registered best_id, which is the
    // value the bus sees on rdata in the same cycle.
    always_comb begin
        for (int n = 0; n < int'(N_interrupts); n++) begin
            state_d[n] = state_q[n];
            unique case (state_q[n])
                StIdle: begin
                    if (interrupt_requests[n]) state_d[n] = StPending;
                end
                StPending: begin
                    if (claim && (best_id_q == 32'(n + 1))) state_d[n] = StInService;
                end
                StInService: begin
                    if (complete && (wdata == 32'(n + 1))) state_d[n] = StIdle;
                end
                default: state_d[n] = StIdle;
            endcase
        end
    end

    // Winner over next-state candidates so a claim or a new request is
    // reflected in best_id one cycle later. A strict compare starting from
    // zero both rejects priority 0 and resolves ties to the lowest ID.
    always_comb begin
        best_prio = 32'd0;
        best_id_d = 32'd0;
        pending_d = '0;
        for (int n = 0; n < int'(N_interrupts); n++) begin
            pending_d[n] = (state_d[n] == StPending);
            if (pending_d[n] && !interrupt_masks[n] &&
                (interrupt_priority_regs[n] > best_prio)) begin
                best_prio = interrupt_priority_regs[n];
                best_id_d = 32'(n + 1);
            end
        end
        req_d = (best_id_d != 32'd0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int n = 0; n < int'(N_interrupts); n++) begin
                state_q[n] <= StIdle;
            end
            pending_q <= '0;
            best_id_q <= 32'd0;
            req_q     <= 1'b0;
        end else begin
            for (int n = 0; n < int'(N_interrupts); n++) begin
                state_q[n] <= state_d[n];
            end
            pending_q <= pending_d;
            best_id_q <= best_id_d;
            req_q     <= req_d;
        end
    end

    assign interrupt_pending = pending_q;
    assign interrupt_req     = req_q;

endmodule

// File: tb/tb_interrupt_claim_arbiter.sv
module tb_interrupt_claim_arbiter;

    localparam int          N  = 32;
    localparam logic [31:0] CC = 32'h0C20_0004;

    logic                clk = 1'b0;
    logic                n_rst;
    logic [N-1:0]        req;
    logic [N-1:0]        mask;
    logic [N-1:0][31:0]  prio;
    logic [31:0]         addr;
    logic                ren;
    logic                wen;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                addr_valid;
    logic [N-1:0]        pend;
    logic                irq;

    interrupt_claim_arbiter #(.N_interrupts(N)) dut (
        .clk                     (clk),
        .n_rst                   (n_rst),
        .interrupt_requests      (req),
        .interrupt_masks         (mask),
        .interrupt_priority_regs (prio),
        .claim_complete_addr     (CC),
        .addr                    (addr),
        .ren                     (ren),
        .wen                     (wen),
        .wdata                   (wdata),
        .rdata                   (rdata),
        .addr_valid              (addr_valid),
        .interrupt_pending       (pend),
        .interrupt_req           (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = pending, 2 = in service.
    int          mst [N];
    logic [31:0] mbest;

    typedef struct {
        logic [31:0] req;
        logic [31:0] mask;
        logic        ren;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_pend;
        logic        exp_req;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic [31:0] r, logic [31:0] m, logic rd, logic wr,
                                logic [31:0] wd, logic [31:0] er, logic [31:0] ep,
                                logic eq);
        vec_t v;
        v.req = r; v.mask = m; v.ren = rd; v.wen = wr; v.wdata = wd;
        v.exp_rdata = er; v.exp_pend = ep; v.exp_req = eq;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Highest priority first, then the lowest ID holding it.
    function automatic logic [31:0] model_winner();
        logic [31:0] maxp = 32'd0;
        for (int n = 0; n < N; n++)
            if (mst[n] == 1 && !mask[n] && prio[n] > maxp) maxp = prio[n];
        if (maxp == 32'd0) return 32'd0;
        for (int n = 0; n < N; n++)
            if (mst[n] == 1 && !mask[n] && prio[n] == maxp) return 32'(n + 1);
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p = 32'd0;
        for (int n = 0; n < N; n++) if (mst[n] == 1) p[n] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) mst[n] = 0;
        mbest = 32'd0;
    endtask

    task automatic model_step();
        bit av       = (addr == CC);
        bit is_claim = ren && av && !wen;
        bit is_comp  = wen && av;
        for (int n = 0; n < N; n++) begin
            if (mst[n] == 0) begin
                if (req[n]) mst[n] = 1;
            end else if (mst[n] == 1) begin
                if (is_claim && mbest == 32'(n + 1)) mst[n] = 2;
            end else begin
                if (is_comp && wdata == 32'(n + 1)) mst[n] = 0;
            end
        end
        mbest = model_winner();
    endtask

    task automatic check_model(string tag);
        chk({tag, " rdata"}, rdata, (addr == CC) ? mbest : 32'd0);
        chk({tag, " addr_valid"}, {31'd0, addr_valid}, {31'd0, addr == CC});
        chk({tag, " pending"}, pend, model_pend());
        chk({tag, " irq"}, {31'd0, irq}, {31'd0, mbest != 32'd0});
    endtask

    // Advance one clock with the currently applied inputs.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        req = '0; mask = '0; prio = '0;
        addr = 32'd0; ren = 1'b0; wen = 1'b0; wdata = 32'd0;
        prio[0] = 1; prio[1] = 2; prio[2] = 3; prio[3] = 5; prio[5] = 7; prio[9] = 7;
        model_reset();

        //           req          mask ren wen wdata rdata pend     irq
        tbl[0]  = mk(32'h8,      0, 0, 0, 0,  0,  32'h0,   0);
        tbl[1]  = mk(32'h0,      0, 1, 0, 0,  4,  32'h8,   1);
        tbl[2]  = mk(32'h224,    0, 0, 0, 0,  0,  32'h0,   0);
        tbl[3]  = mk(32'h0,      0, 1, 0, 0,  6,  32'h224, 1);
        tbl[4]  = mk(32'h0,      0, 1, 0, 0,  10, 32'h204, 1);
        tbl[5]  = mk(32'h0,      0, 1, 0, 0,  3,  32'h004, 1);
        tbl[6]  = mk(32'h0,      0, 1, 0, 0,  0,  32'h0,   0);
        tbl[7]  = mk(32'h8,      0, 0, 1, 4,  0,  32'h0,   0);
        tbl[8]  = mk(32'h8,      0, 0, 0, 0,  0,  32'h0,   0);
        tbl[9]  = mk(32'h0,      0, 1, 0, 0,  4,  32'h8,   1);
        tbl[10] = mk(32'h0,      0, 0, 1, 0,  0,  32'h0,   0);
        tbl[11] = mk(32'h0,      0, 0, 1, 33, 0,  32'h0,   0);
        tbl[12] = mk(32'h1,      1, 0, 0, 0,  0,  32'h0,   0);
        tbl[13] = mk(32'h0,      1, 1, 0, 0,  0,  32'h1,   0);
        tbl[14] = mk(32'h0,      1, 0, 1, 1,  0,  32'h1,   0);
        tbl[15] = mk(32'h0,      0, 0, 0, 0,  0,  32'h1,   0);
        tbl[16] = mk(32'h0,      0, 1, 0, 0,  1,  32'h1,   1);
        tbl[17] = mk(32'h2,      0, 0, 0, 0,  0,  32'h0,   0);
        tbl[18] = mk(32'h0,      0, 1, 1, 1,  2,  32'h2,   1);
        tbl[19] = mk(32'h0,      0, 0, 0, 0,  2,  32'h2,   1);
        tbl[20] = mk(32'h0,      0, 0, 1, 1,  2,  32'h2,   1);

        // Reset state, with and without a matching address.
        #2;
        chk("reset rdata", rdata, 32'd0);
        chk("reset addr_valid", {31'd0, addr_valid}, 32'd0);
        chk("reset pending", pend, 32'd0);
        chk("reset irq", {31'd0, irq}, 32'd0);
        addr = CC;
        #1;
        chk("reset rdata at cc", rdata, 32'd0);
        chk("reset addr_valid at cc", {31'd0, addr_valid}, 32'd1);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req = tbl[i].req; mask = tbl[i].mask; ren = tbl[i].ren;
            wen = tbl[i].wen; wdata = tbl[i].wdata;
            #1;
            chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d pending", i), pend, tbl[i].exp_pend);
            chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_req});
            check_model($sformatf("vec%0d model", i));
            cycle();
        end

        // Reset mid-service: sources 2,3,5,9 in service, source 1 pending.
        req = 32'h26; ren = 1'b0; wen = 1'b0; wdata = 32'd0;
        n_rst = 1'b0;
        #1;
        chk("midrst pending", pend, 32'd0);
        chk("midrst irq", {31'd0, irq}, 32'd0);
        chk("midrst rdata", rdata, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        chk("midrst held pending", pend, 32'd0);
        cycle();
        chk("post-rst pending", pend, 32'h26);
        chk("post-rst irq", {31'd0, irq}, 32'd1);
        chk("post-rst rdata", rdata, 32'd6);
        check_model("post-rst model");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                for (int n = 0; n < N; n++) prio[n] = $urandom_range(0, 3);
            req = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) mask = $urandom & $urandom;
            addr = ($urandom_range(0, 9) == 0) ? $urandom : CC;
            ren = ($urandom_range(0, 2) == 0);
            wen = ($urandom_range(0, 3) == 0);
            wdata = $urandom_range(0, 34);
            if ($urandom_range(0, 1) == 1) begin
                int k = $urandom_range(0, N - 1);
                for (int j = 0; j < N; j++) begin
                    if (mst[(k + j) % N] == 2) begin
                        wdata = 32'((k + j) % N + 1);
                        break;
                    end
                end
            end
            #1;
            check_model($sformatf("rnd%0d", i));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
